// File: rtl/gen_fir_seq_if.sv
// Datapath/log-memory control bundle for gen_fir_seq.
// master = software/bench side, slave = the sequencer.
interface gen_fir_seq_if #(
  parameter int NB_SEL    = 2,
  parameter int NB_DWELL  = 12,
  parameter int NB_ADDR   = 10,
  parameter int NB_SETTLE = 4
);
  logic                   i_start;
  logic                   i_abort;
  logic [2**NB_SEL-1:0]   i_sel_mask;
  logic [NB_DWELL-1:0]    i_dwell;
  logic [NB_SETTLE-1:0]   i_settle;
  logic                   o_enable;
  logic [NB_SEL-1:0]      o_sel;
  logic                   o_log_we;
  logic [NB_ADDR-1:0]     o_log_addr;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_full;
  logic                   o_err;

  modport master (
    output i_start, i_abort, i_sel_mask, i_dwell, i_settle,
    input  o_enable, o_sel, o_log_we, o_log_addr, o_busy, o_done, o_full, o_err
  );

  modport slave (
    input  i_start, i_abort, i_sel_mask, i_dwell, i_settle,
    output o_enable, o_sel, o_log_we, o_log_addr, o_busy, o_done, o_full, o_err
  );
endinterface

// File: rtl/gen_fir_seq.sv
// Capture sequencer: steps the generator source select through a mask and logs dwell samples per source.
// Optional GEN_FIR_SEQ_LOOP_EN: wrap back to the lowest source and run until memory full or abort.
module gen_fir_seq #(
  parameter int NB_SEL    = 2,
  parameter int NB_DWELL  = 12,
  parameter int NB_ADDR   = 10,
  parameter int NB_SETTLE = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  gen_fir_seq_if.slave bus
);
  localparam int unsigned NSRC = 2**NB_SEL;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_LOG, S_NEXT, S_DONE} state_t;

  state_t               state;
  logic [NSRC-1:0]      mask_q;
  logic [NB_DWELL-1:0]  dwell_q;
  logic [NB_SETTLE-1:0] settle_q;
  logic [NB_SETTLE-1:0] settle_cnt;
  logic [NB_DWELL-1:0]  dwell_cnt;

  logic                 enable_q;
  logic [NB_SEL-1:0]    sel_q;
  logic                 we_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 full_q;
  logic                 err_q;

  logic [NB_SEL-1:0]    low_sel;
  logic                 nxt_found;
  logic [NB_SEL-1:0]    nxt_sel;
`ifdef GEN_FIR_SEQ_LOOP_EN
  logic [NB_SEL-1:0]    wrap_sel;
`endif

  // Descending scans so the last hit is the lowest qualifying index.
  always_comb begin
    low_sel   = '0;
    nxt_found = 1'b0;
    nxt_sel   = sel_q;
`ifdef GEN_FIR_SEQ_LOOP_EN
    wrap_sel  = '0;
`endif
    for (int unsigned k = NSRC; k > 0; k--) begin
      if (bus.i_sel_mask[NB_SEL'(k - 1)])
        low_sel = NB_SEL'(k - 1);
      if (mask_q[NB_SEL'(k - 1)] && (NB_SEL'(k - 1) > sel_q)) begin
        nxt_found = 1'b1;
        nxt_sel   = NB_SEL'(k - 1);
      end
`ifdef GEN_FIR_SEQ_LOOP_EN
      if (mask_q[NB_SEL'(k - 1)])
        wrap_sel = NB_SEL'(k - 1);
`endif
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= S_IDLE;
      mask_q     <= '0;
      dwell_q    <= '0;
      settle_q   <= '0;
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      enable_q   <= 1'b0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state != S_IDLE && bus.i_abort) begin
        // A write in flight on the abort edge still lands, so the address reflects it.
        state    <= S_IDLE;
        enable_q <= 1'b0;
        we_q     <= 1'b0;
        busy_q   <= 1'b0;
        if (we_q) begin
          if (addr_q == '1) full_q <= 1'b1;
          else              addr_q <= addr_q + NB_ADDR'(1);
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.i_start && !bus.i_abort) begin
              if (bus.i_sel_mask != '0 && bus.i_dwell != '0) begin
                state      <= S_SETTLE;
                mask_q     <= bus.i_sel_mask;
                dwell_q    <= bus.i_dwell;
                settle_q   <= bus.i_settle;
                settle_cnt <= '0;
                sel_q      <= low_sel;
                addr_q     <= '0;
                full_q     <= 1'b0;
                enable_q   <= 1'b1;
                busy_q     <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_SETTLE: begin
            if (settle_cnt == settle_q) begin
              state     <= S_LOG;
              we_q      <= 1'b1;
              dwell_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + NB_SETTLE'(1);
            end
          end
          S_LOG: begin
            if (addr_q == '1) begin
              state    <= S_DONE;
              full_q   <= 1'b1;
              done_q   <= 1'b1;
              enable_q <= 1'b0;
              we_q     <= 1'b0;
            end else begin
              addr_q <= addr_q + NB_ADDR'(1);
              if (dwell_cnt == dwell_q - NB_DWELL'(1)) begin
                state <= S_NEXT;
                we_q  <= 1'b0;
              end else begin
                dwell_cnt <= dwell_cnt + NB_DWELL'(1);
              end
            end
          end
          S_NEXT: begin
            if (nxt_found) begin
              state      <= S_SETTLE;
              sel_q      <= nxt_sel;
              settle_cnt <= '0;
            end else begin
`ifdef GEN_FIR_SEQ_LOOP_EN
              state      <= S_SETTLE;
              sel_q      <= wrap_sel;
              settle_cnt <= '0;
`else
              state    <= S_DONE;
              done_q   <= 1'b1;
              enable_q <= 1'b0;
`endif
            end
          end
          S_DONE: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_enable   = enable_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_log_we   = we_q;
  assign bus.o_log_addr = addr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_full     = full_q;
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_gen_fir_seq.sv
// Directed bench for gen_fir_seq: three instances (default, 8-entry and 16-entry log memory).
// Expectations follow GEN_FIR_SEQ_LOOP_EN when the bench is built with it.
module tb_gen_fir_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gen_fir_seq_if #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(10), .NB_SETTLE(4)) bm ();
  gen_fir_seq_if #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(3),  .NB_SETTLE(4)) bs ();
  gen_fir_seq_if #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(4),  .NB_SETTLE(4)) bl ();

  gen_fir_seq #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(10), .NB_SETTLE(4)) u_main (
    .i_clock(clk), .i_reset(rst), .bus(bm));
  gen_fir_seq #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(3), .NB_SETTLE(4)) u_small (
    .i_clock(clk), .i_reset(rst), .bus(bs));
  gen_fir_seq #(.NB_SEL(2), .NB_DWELL(12), .NB_ADDR(4), .NB_SETTLE(4)) u_loop (
    .i_clock(clk), .i_reset(rst), .bus(bl));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bm.i_start = 1'b1; bm.i_sel_mask = 4'hF; bm.i_dwell = 12'd3; bm.i_settle = 4'd2;
    repeat (3) tick;
    checks++; if (bm.o_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", bm.o_enable); end
    checks++; if (bm.o_sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bm.o_sel); end
    checks++; if (bm.o_log_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bm.o_log_we); end
    checks++; if (bm.o_log_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bm.o_log_addr); end
    checks++; if (bm.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bm.o_busy); end
    checks++; if ({bm.o_done, bm.o_full, bm.o_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got done/full/err=%b expected 000", {bm.o_done, bm.o_full, bm.o_err}); end
    checks++; if ({bs.o_busy, bl.o_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_busy_others: got %b expected 00", {bs.o_busy, bl.o_busy}); end
    bm.i_start = 1'b0;
    rst = 1'b1;
    tick;
    checks++; if (bm.o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", bm.o_busy); end
  endtask

  task automatic test_basic;
    int cyc, nwr, ndone, first_cyc, src2_cyc, done_cyc;
    bit fin;
    logic [9:0] addrs[16];
    logic [1:0] sels[16];
    nwr = 0; ndone = 0; first_cyc = -1; src2_cyc = -1; done_cyc = -1; fin = 1'b0;
    bm.i_sel_mask = 4'b1010; bm.i_dwell = 12'd3; bm.i_settle = 4'd2; bm.i_start = 1'b1;
    tick;
    bm.i_start = 1'b0;
    cyc = 1;
    checks++; if ({bm.o_busy, bm.o_enable, bm.o_log_we} !== 3'b110) begin
      errors++; $display("FAIL basic_entry: got busy/en/we=%b expected 110", {bm.o_busy, bm.o_enable, bm.o_log_we}); end
    checks++; if (bm.o_sel !== 2'd1) begin errors++; $display("FAIL basic_first_sel: got %0d expected 1", bm.o_sel); end
    for (int n = 0; n < 100 && !fin; n++) begin
      if (bm.o_log_we) begin
        if (nwr < 16) begin addrs[nwr] = bm.o_log_addr; sels[nwr] = bm.o_sel; end
        if (nwr == 0) first_cyc = cyc;
        if (nwr == 3) src2_cyc = cyc;
        nwr++;
      end
      if (bm.o_done) begin ndone++; done_cyc = cyc; end
      if (ndone > 0 && !bm.o_busy) fin = 1'b1;
      else begin
        // Changes after start must not affect the running capture.
        if (cyc == 2) begin bm.i_sel_mask = 4'b0001; bm.i_dwell = 12'd1; bm.i_settle = 4'd0; end
        bm.i_start = (cyc == 5);
        tick;
        cyc++;
      end
    end
    bm.i_start = 1'b0;
    checks++; if (!fin) begin errors++; $display("FAIL basic_timeout: got no completion expected done within 100 cycles"); end
    checks++; if (nwr !== 6) begin errors++; $display("FAIL basic_nwr: got %0d expected 6", nwr); end
    checks++; if (first_cyc !== 4) begin errors++; $display("FAIL basic_first_write_cycle: got %0d expected 4", first_cyc); end
    checks++; if (src2_cyc !== 11) begin errors++; $display("FAIL basic_src2_cycle: got %0d expected 11", src2_cyc); end
    checks++; if (done_cyc !== 15) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 15", done_cyc); end
    for (int i = 0; i < 6 && i < nwr; i++) begin
      checks++; if (addrs[i] !== 10'(i)) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, addrs[i], i); end
      checks++; if (sels[i] !== ((i < 3) ? 2'd1 : 2'd3)) begin
        errors++; $display("FAIL basic_sel[%0d]: got %0d expected %0d", i, sels[i], (i < 3) ? 1 : 3); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", ndone); end
    checks++; if (bm.o_full !== 1'b0) begin errors++; $display("FAIL basic_full: got %b expected 0", bm.o_full); end
    checks++; if (bm.o_log_addr !== 10'd6) begin errors++; $display("FAIL basic_final_addr: got %0d expected 6", bm.o_log_addr); end
  endtask

  task automatic test_reject;
    bm.i_sel_mask = 4'b0000; bm.i_dwell = 12'd3; bm.i_settle = 4'd0; bm.i_start = 1'b1;
    tick;
    bm.i_start = 1'b0;
    checks++; if (bm.o_err !== 1'b1) begin errors++; $display("FAIL reject_mask_err: got %b expected 1", bm.o_err); end
    checks++; if ({bm.o_busy, bm.o_enable, bm.o_log_we} !== 3'b000) begin
      errors++; $display("FAIL reject_mask_idle: got busy/en/we=%b expected 000", {bm.o_busy, bm.o_enable, bm.o_log_we}); end
    tick;
    checks++; if (bm.o_err !== 1'b0) begin errors++; $display("FAIL reject_err_pulse: got %b expected 0", bm.o_err); end
    bm.i_sel_mask = 4'b0100; bm.i_dwell = 12'd0; bm.i_start = 1'b1;
    tick;
    bm.i_start = 1'b0;
    checks++; if (bm.o_err !== 1'b1) begin errors++; $display("FAIL reject_dwell_err: got %b expected 1", bm.o_err); end
    checks++; if ({bm.o_busy, bm.o_log_we} !== 2'b00) begin
      errors++; $display("FAIL reject_dwell_idle: got busy/we=%b expected 00", {bm.o_busy, bm.o_log_we}); end
    tick;
    checks++; if ({bm.o_err, bm.o_busy, bm.o_log_we} !== 3'b000) begin
      errors++; $display("FAIL reject_after: got err/busy/we=%b expected 000", {bm.o_err, bm.o_busy, bm.o_log_we}); end
  endtask

  task automatic test_full;
    int cyc, nwr, ndone, first_cyc, done_cyc, late_wr;
    bit fin;
    logic [2:0] addrs[16];
    logic [1:0] sels[16];
    nwr = 0; ndone = 0; first_cyc = -1; done_cyc = -1; late_wr = 0; fin = 1'b0;
    bs.i_sel_mask = 4'b0011; bs.i_dwell = 12'd6; bs.i_settle = 4'd0; bs.i_start = 1'b1;
    tick;
    bs.i_start = 1'b0;
    cyc = 1;
    for (int n = 0; n < 100 && !fin; n++) begin
      if (bs.o_log_we) begin
        if (nwr < 16) begin addrs[nwr] = bs.o_log_addr; sels[nwr] = bs.o_sel; end
        if (nwr == 0) first_cyc = cyc;
        nwr++;
      end
      if (bs.o_done) begin ndone++; done_cyc = cyc; end
      if (ndone > 0 && !bs.o_busy) fin = 1'b1;
      else begin tick; cyc++; end
    end
    checks++; if (!fin) begin errors++; $display("FAIL full_timeout: got no completion expected done within 100 cycles"); end
    checks++; if (nwr !== 8) begin errors++; $display("FAIL full_nwr: got %0d expected 8", nwr); end
    checks++; if (first_cyc !== 2) begin errors++; $display("FAIL full_first_write_cycle: got %0d expected 2", first_cyc); end
    checks++; if (done_cyc !== 12) begin errors++; $display("FAIL full_done_cycle: got %0d expected 12", done_cyc); end
    for (int i = 0; i < 8 && i < nwr; i++) begin
      checks++; if (addrs[i] !== 3'(i)) begin errors++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, addrs[i], i); end
      checks++; if (sels[i] !== ((i < 6) ? 2'd0 : 2'd1)) begin
        errors++; $display("FAIL full_sel[%0d]: got %0d expected %0d", i, sels[i], (i < 6) ? 0 : 1); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", ndone); end
    checks++; if (bs.o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", bs.o_full); end
    checks++; if (bs.o_log_addr !== 3'd7) begin errors++; $display("FAIL full_addr_hold: got %0d expected 7", bs.o_log_addr); end
    for (int n = 0; n < 4; n++) begin
      tick;
      if (bs.o_log_we) late_wr++;
    end
    checks++; if (late_wr !== 0) begin errors++; $display("FAIL full_no_wrap_write: got %0d writes expected 0", late_wr); end
    checks++; if (bs.o_full !== 1'b1) begin errors++; $display("FAIL full_sticky: got %b expected 1", bs.o_full); end
    bs.i_sel_mask = 4'b0001; bs.i_dwell = 12'd1; bs.i_start = 1'b1;
    tick;
    bs.i_start = 1'b0;
    checks++; if ({bs.o_full, bs.o_busy} !== 2'b01) begin
      errors++; $display("FAIL full_clear_on_start: got full/busy=%b expected 01", {bs.o_full, bs.o_busy}); end
    checks++; if (bs.o_log_addr !== 3'd0) begin errors++; $display("FAIL full_restart_addr: got %0d expected 0", bs.o_log_addr); end
    fin = 1'b0;
    for (int n = 0; n < 20 && !fin; n++) begin
      tick;
      if (!bs.o_busy) fin = 1'b1;
    end
    checks++; if (!fin) begin errors++; $display("FAIL full_restart_timeout: got busy expected idle within 20 cycles"); end
  endtask

  task automatic test_abort;
    int bad;
    bm.i_sel_mask = 4'b0001; bm.i_dwell = 12'd5; bm.i_settle = 4'd1; bm.i_start = 1'b1;
    tick;
    bm.i_start = 1'b0;
    repeat (3) tick;
    checks++; if ({bm.o_log_we, bm.o_log_addr} !== {1'b1, 10'd1}) begin
      errors++; $display("FAIL abort_second_log: got we=%b addr=%0d expected we=1 addr=1", bm.o_log_we, bm.o_log_addr); end
    bm.i_abort = 1'b1;
    tick;
    bm.i_abort = 1'b0;
    checks++; if ({bm.o_enable, bm.o_log_we, bm.o_busy} !== 3'b000) begin
      errors++; $display("FAIL abort_outputs: got en/we/busy=%b expected 000", {bm.o_enable, bm.o_log_we, bm.o_busy}); end
    checks++; if (bm.o_log_addr !== 10'd2) begin errors++; $display("FAIL abort_addr: got %0d expected 2", bm.o_log_addr); end
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      if (bm.o_done || bm.o_log_we) bad++;
      tick;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done/write cycles expected 0", bad); end
    bm.i_sel_mask = 4'b0001; bm.i_dwell = 12'd1; bm.i_settle = 4'd0;
    bm.i_abort = 1'b1; bm.i_start = 1'b1;
    tick;
    bm.i_abort = 1'b0; bm.i_start = 1'b0;
    checks++; if ({bm.o_busy, bm.o_err, bm.o_log_addr} !== {1'b0, 1'b0, 10'd2}) begin
      errors++; $display("FAIL abort_beats_start: got busy=%b err=%b addr=%0d expected busy=0 err=0 addr=2", bm.o_busy, bm.o_err, bm.o_log_addr); end
    bm.i_start = 1'b1;
    tick;
    bm.i_start = 1'b0;
    checks++; if ({bm.o_busy, bm.o_log_addr} !== {1'b1, 10'd0}) begin
      errors++; $display("FAIL abort_restart: got busy=%b addr=%0d expected busy=1 addr=0", bm.o_busy, bm.o_log_addr); end
    tick;
    checks++; if (bm.o_log_we !== 1'b1) begin errors++; $display("FAIL abort_restart_we: got %b expected 1", bm.o_log_we); end
    rst = 1'b0;
    tick;
    rst = 1'b1;
    checks++; if ({bm.o_enable, bm.o_log_we, bm.o_busy, bm.o_done, bm.o_sel, bm.o_log_addr} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got en=%b we=%b busy=%b done=%b sel=%0d addr=%0d expected all 0",
                         bm.o_enable, bm.o_log_we, bm.o_busy, bm.o_done, bm.o_sel, bm.o_log_addr); end
    tick;
    checks++; if ({bm.o_done, bm.o_busy} !== 2'b00) begin
      errors++; $display("FAIL midreset_no_done: got done/busy=%b expected 00", {bm.o_done, bm.o_busy}); end
  endtask

  task automatic test_loop;
    int nwr, ndone, exp_nwr;
    bit fin;
    logic [3:0] addrs[32];
    logic [1:0] sels[32];
    nwr = 0; ndone = 0; fin = 1'b0;
    bl.i_sel_mask = 4'b0101; bl.i_dwell = 12'd5; bl.i_settle = 4'd1; bl.i_start = 1'b1;
    tick;
    bl.i_start = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      if (bl.o_log_we) begin
        if (nwr < 32) begin addrs[nwr] = bl.o_log_addr; sels[nwr] = bl.o_sel; end
        nwr++;
      end
      if (bl.o_done) ndone++;
      if (ndone > 0 && !bl.o_busy) fin = 1'b1;
      else tick;
    end
    checks++; if (!fin) begin errors++; $display("FAIL loop_timeout: got no completion expected done within 200 cycles"); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL loop_done_count: got %0d expected 1", ndone); end
`ifdef GEN_FIR_SEQ_LOOP_EN
    exp_nwr = 16;
    checks++; if (nwr !== exp_nwr) begin errors++; $display("FAIL loop_nwr: got %0d expected %0d", nwr, exp_nwr); end
    if (nwr >= 16) begin
      checks++; if ({sels[0], sels[5], sels[10], sels[15]} !== {2'd0, 2'd2, 2'd0, 2'd2}) begin
        errors++; $display("FAIL loop_order: got %0d,%0d,%0d,%0d expected 0,2,0,2", sels[0], sels[5], sels[10], sels[15]); end
      checks++; if (addrs[15] !== 4'd15) begin errors++; $display("FAIL loop_last_addr: got %0d expected 15", addrs[15]); end
    end
    checks++; if ({bl.o_full, bl.o_log_addr} !== {1'b1, 4'd15}) begin
      errors++; $display("FAIL loop_end_state: got full=%b addr=%0d expected full=1 addr=15", bl.o_full, bl.o_log_addr); end
`else
    exp_nwr = 10;
    checks++; if (nwr !== exp_nwr) begin errors++; $display("FAIL loop_nwr: got %0d expected %0d", nwr, exp_nwr); end
    if (nwr >= 10) begin
      checks++; if ({sels[0], sels[4], sels[5], sels[9]} !== {2'd0, 2'd0, 2'd2, 2'd2}) begin
        errors++; $display("FAIL loop_order: got %0d,%0d,%0d,%0d expected 0,0,2,2", sels[0], sels[4], sels[5], sels[9]); end
      checks++; if (addrs[9] !== 4'd9) begin errors++; $display("FAIL loop_last_addr: got %0d expected 9", addrs[9]); end
    end
    checks++; if ({bl.o_full, bl.o_log_addr} !== {1'b0, 4'd10}) begin
      errors++; $display("FAIL loop_end_state: got full=%b addr=%0d expected full=0 addr=10", bl.o_full, bl.o_log_addr); end
`endif
  endtask

  initial begin
    rst = 1'b0;
    bm.i_start = 1'b0; bm.i_abort = 1'b0; bm.i_sel_mask = '0; bm.i_dwell = '0; bm.i_settle = '0;
    bs.i_start = 1'b0; bs.i_abort = 1'b0; bs.i_sel_mask = '0; bs.i_dwell = '0; bs.i_settle = '0;
    bl.i_start = 1'b0; bl.i_abort = 1'b0; bl.i_sel_mask = '0; bl.i_dwell = '0; bl.i_settle = '0;
    test_reset;
    test_basic;
    test_reject;
    test_full;
    test_abort;
    test_loop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion by 500us");
    $fatal(1);
  end
endmodule

// File: doc/gen_fir_seq.md
Name: gen_fir_seq

Overview:
Capture sequencer for the signal-generator/FIR datapath in the logging project. On a start pulse it steps the generator source select through every source enabled in a mask. For each source it enables the datapath, waits a programmable number of cycles for the filter pipeline to flush, then writes a fixed number of filtered samples into the log memory at consecutive addresses. It drives the datapath enable/select inputs and the log-memory write port; the filtered sample itself goes straight from the datapath to the memory data input.

Parameters:
NB_SEL, 2, width of source select; number of sources = 2**NB_SEL
NB_DWELL, 12, width of samples-per-source count
NB_ADDR, 10, log memory address width (depth 2**NB_ADDR)
NB_SETTLE, 4, width of settle-cycle count

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_start  in  1  start-capture pulse, sampled only in IDLE
i_abort  in  1  abort request, any state
i_sel_mask  in  2**NB_SEL  bit k=1 -> source k included in the sequence
i_dwell  in  NB_DWELL  samples logged per source; latched at start
i_settle  in  NB_SETTLE  flush cycles after each select change; latched at start
o_enable  out  1  datapath enable
o_sel  out  NB_SEL  datapath source select
o_log_we  out  1  log memory write enable
o_log_addr  out  NB_ADDR  log memory write address
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse when a capture ends normally or on memory full
o_full  out  1  sticky: memory filled before the sequence finished; cleared by next accepted start
o_err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- All outputs are registered. While i_reset=0 at a clock edge: state=IDLE, all outputs 0, latched mask/dwell/settle 0.
- States and transitions:
  - IDLE -> SETTLE on i_start=1, only if i_sel_mask!=0 and i_dwell!=0.
    - On that edge: latch mask, dwell, settle; o_sel = lowest set mask bit; o_log_addr=0; o_full=0.
    - If the mask or dwell is zero: stay in IDLE and pulse o_err for 1 cycle.
  - SETTLE: o_enable=1, o_log_we=0.
    - Counts latched settle cycles, then moves to LOG.
    - settle=0 -> exactly 1 cycle in SETTLE.
  - LOG: o_enable=1, o_log_we=1 for exactly dwell consecutive cycles.
    - o_log_addr increments by 1 after each write.
    - After the dwell-th write -> NEXT.
  - NEXT (1 cycle): o_enable=1, o_log_we=0.
    - Searches for the next set mask bit strictly above the current o_sel.
    - Found -> o_sel updated, go to SETTLE.
    - Not found -> DONE.
  - DONE (1 cycle): o_done=1, o_enable=0, o_log_we=0 -> IDLE.
- First write occurs on cycle settle+2 after the start edge (1 cycle of state entry + settle+1 SETTLE cycles).
- Memory full: a write to address 2**NB_ADDR-1 sets o_full and forces DONE on the next edge.
  - The address does not wrap.
  - Remaining samples and sources are skipped.
- Abort: i_abort=1 in any non-IDLE state -> IDLE on the next edge.
  - o_enable and o_log_we go to 0 on that edge.
  - o_done is not pulsed; o_log_addr holds, so software can read the partial length.
- i_abort and i_start together in IDLE: abort wins and the start is ignored.
- i_start outside IDLE: ignored.
- Changes to i_sel_mask, i_dwell or i_settle during a capture: no effect.
- Reset mid-capture: same as power-on reset; no done pulse.

Optional Feature:
GEN_FIR_SEQ_LOOP_EN
- Defined: in NEXT, when no higher mask bit exists, wrap to the lowest set bit and continue to SETTLE instead of DONE.
  - Capture ends only on memory full (o_done=1, o_full=1) or abort.
- Undefined: single pass as described above.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_start=1 -> all outputs 0, o_busy=0.
- Basic pass: mask=4'b1010, dwell=3, settle=2, start pulse.
  - o_sel=1; first o_log_we on cycle 4 after start; writes at addr 0,1,2.
  - NEXT, then o_sel=3; writes at addr 3,4,5.
  - o_done pulses once; 6 writes total; o_full=0.
- Reject: start with mask=0, then start with dwell=0 -> o_err pulses twice, o_busy stays 0, no writes.
- Full: NB_ADDR=3, mask=4'b0011, dwell=6, settle=0.
  - 6 writes for source 0, then 2 for source 1 (addr 6,7).
  - o_full=1, o_done pulses; no write to addr 0 afterwards.
- Abort: abort asserted on the 2nd LOG cycle -> next cycle o_enable=0, o_log_we=0, o_log_addr=2, no o_done; a new start then resets addr to 0.
- Loop (GEN_FIR_SEQ_LOOP_EN): NB_ADDR=4, mask=4'b0101, dwell=5.
  - Sources visited in order 0,2,0,2.
  - Ends at addr 15 with o_full=1 and o_done pulsed; without the macro, done occurs after 10 writes.
